// File: rtl/dct_coef_collector.sv
// dct_coef_collector: captures scaled and saturated MAC results into a 64-entry block
// buffer, one per ready_in rising edge at raster address {y,x}. Once all 64 distinct
// addresses are written, the block drains over a valid/ready stream.
// Optional build macro DCT_COEF_ZIGZAG_EN: when defined, the drain follows the 8x8
// zigzag scan. Otherwise the drain is in raster order.

// Scales one accumulator value: arithmetic shift, then clamp to the signed OUT_W range.
module dct_coef_scale #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 3
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] coef
);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  // shift then saturate; in-range values keep only their low OUT_W bits
  always_comb begin
    shifted = $signed(acc) >>> SHIFT;
    if (shifted > SAT_MAX)      coef = {1'b0, {(OUT_W-1){1'b1}}};
    else if (shifted < SAT_MIN) coef = {1'b1, {(OUT_W-1){1'b0}}};
    else                        coef = shifted[OUT_W-1:0];
  end
endmodule

module dct_coef_collector #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [2:0]       x_in,
  input  logic [2:0]       y_in,
  input  logic [ACC_W-1:0] acc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [5:0]       out_index,
  output logic             out_last,
  output logic             busy,
  output logic             overflow_err
);

`ifdef DCT_COEF_ZIGZAG_EN
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
`endif

  // drain position k -> raster address
  function automatic logic [5:0] order(input logic [5:0] idx);
`ifdef DCT_COEF_ZIGZAG_EN
    return ZZ[idx];
`else
    return idx;
`endif
  endfunction

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t           state;
  logic             ready_q;
  logic             cap;
  logic [63:0]      written;
  logic [6:0]       count;
  logic [5:0]       k;
  logic [5:0]       wr_addr;
  logic [OUT_W-1:0] scaled;
  logic             hs;
  logic [OUT_W-1:0] mem [64];

  assign cap     = ready_in & ~ready_q;
  assign wr_addr = {y_in, x_in};
  assign hs      = out_valid & out_ready;

  dct_coef_scale #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_scale (
    .acc  (acc_in),
    .coef (scaled)
  );

  // The buffer is frozen during DRAIN, so reading it directly keeps out_data stable.
  // The value is forced to zero whenever nothing is offered.
  assign out_data = out_valid ? mem[out_index] : '0;

  // one-flop history so a strobe held high for several cycles captures only once
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) ready_q <= 1'b0;
    else         ready_q <= ready_in;
  end

  // coefficient buffer: written only while collecting; rewriting an address is allowed
  always_ff @(posedge clk) begin
    if (cap && state == COLLECT) mem[wr_addr] <= scaled;
  end

  // collect/drain sequencing, bitmap and count, registered stream outputs
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state        <= COLLECT;
      written      <= '0;
      count        <= '0;
      k            <= '0;
      out_valid    <= 1'b0;
      out_index    <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (cap && !written[wr_addr]) begin
            written[wr_addr] <= 1'b1;
            count            <= count + 7'd1;
            if (count == 7'd63) begin
              state     <= DRAIN;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              k         <= '0;
              out_index <= order(6'd0);
              out_last  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // strobes cannot be stored while the block is draining, including the last handshake cycle
          if (cap) overflow_err <= 1'b1;
          if (hs) begin
            if (k == 6'd63) begin
              state     <= COLLECT;
              k         <= '0;
              written   <= '0;
              count     <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_index <= '0;
              out_last  <= 1'b0;
            end else begin
              k         <= k + 6'd1;
              out_index <= order(k + 6'd1);
              out_last  <= (k == 6'd62);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_dct_coef_collector.sv
// Bench for dct_coef_collector. It compares random and directed blocks against a
// behavioural model made of a scaled-value array and a scan list built by walking the
// 8x8 block diagonals.
module tb_dct_coef_collector;
  localparam int ACC_W = 24;
  localparam int OUT_W = 16;
  localparam int SHIFT = 3;

  logic             clk = 1'b0;
  logic             rst_in = 1'b0;
  logic             ready_in = 1'b0;
  logic [2:0]       x_in = '0;
  logic [2:0]       y_in = '0;
  logic [ACC_W-1:0] acc_in = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic [5:0]       out_index;
  logic             out_last;
  logic             busy;
  logic             overflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_mem [64];
  logic [5:0]  scan [64];
  logic [15:0] got_data [64];
  logic [5:0]  got_idx [64];
  logic        got_last [64];
  logic [15:0] got_by_idx [64];
  int          got_n;

  dct_coef_collector #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_in(rst_in), .ready_in(ready_in), .x_in(x_in), .y_in(y_in),
    .acc_in(acc_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // floor(acc / 2^SHIFT), then clamp to the signed OUT_W range
  function automatic logic [15:0] ref_scale(input logic [ACC_W-1:0] a);
    longint v, q, div, hi, lo;
    v = longint'(a);
    if (a[ACC_W-1]) v = v - (longint'(1) << ACC_W);
    div = longint'(1) << SHIFT;
    q = (v >= 0) ? v / div : -((-v + div - 1) / div);
    hi = (longint'(1) << (OUT_W-1)) - 1;
    lo = -hi - 1;
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q[15:0];
  endfunction

  function automatic logic [ACC_W-1:0] rand_acc();
    logic [ACC_W-1:0] r;
    r = ACC_W'($urandom);
    if ($urandom_range(1) == 1) r = {{(ACC_W-19){r[18]}}, r[18:0]};
    return r;
  endfunction

  task automatic build_scan();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
`ifdef DCT_COEF_ZIGZAG_EN
      if (s % 2 == 0) begin
        for (int y = (s < 7 ? s : 7); y >= (s > 7 ? s - 7 : 0); y--) begin
          scan[n] = 6'(8 * y + (s - y)); n++;
        end
      end else begin
        for (int y = (s > 7 ? s - 7 : 0); y <= (s < 7 ? s : 7); y++) begin
          scan[n] = 6'(8 * y + (s - y)); n++;
        end
      end
`else
      if (s < 8) for (int j = 0; j < 8; j++) begin scan[n] = 6'(n); n++; end
`endif
    end
  endtask

  // One capture at raster address a. For hold > 1, acc_in is scrambled after the first cycle.
  task automatic strobe(input logic [5:0] a, input logic [ACC_W-1:0] acc, input int hold);
    @(posedge clk); #1;
    ready_in = 1'b1; x_in = a[2:0]; y_in = a[5:3]; acc_in = acc;
    exp_mem[a] = ref_scale(acc);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      acc_in = rand_acc();
    end
    @(posedge clk); #1;
    ready_in = 1'b0;
  endtask

  // Sends every address except skip, in shuffled order, with occasional rewrites of addresses already sent.
  task automatic send_shuffled(input int skip, input int dup_pct);
    int perm [64];
    int j, t, d;
    for (int i = 0; i < 64; i++) perm[i] = i;
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(i)); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 64; i++) begin
      if (perm[i] != skip) begin
        if (i > 0 && int'($urandom_range(99)) < dup_pct) begin
          d = perm[$urandom_range(i - 1)];
          if (d != skip) strobe(6'(d), rand_acc(), 1);
        end
        strobe(6'(perm[i]), rand_acc(), int'($urandom_range(1, 3)));
      end
    end
  endtask

  // Drains one block with random backpressure and optional stall/strobe injection, then compares it with the model.
  task automatic drain_block(input string tag, input int pct, input int stall_at,
                             input int ovf_at, input bit last_strobe, input logic [5:0] last_addr);
    int cyc = 0;
    bit stalled = 0, ovf_done = 0;
    logic [15:0] sd;
    logic [5:0]  si;
    got_n = 0;
    while (got_n < 64 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      ready_in = 1'b0;
      if (stall_at == got_n && !stalled) begin
        stalled = 1; sd = out_data; si = out_index; out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_cmp++;
          if (out_valid !== 1'b1 || out_data !== sd || out_index !== si) begin
            n_bad++;
            $display("FAIL %s stall cycle %0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                     tag, s, out_valid, out_data, out_index, sd, si);
          end
          @(posedge clk); #1;
        end
      end
      out_ready = (int'($urandom_range(99)) < pct);
      if (ovf_at == got_n && !ovf_done) begin
        ovf_done = 1; ready_in = 1'b1;
        x_in = 3'($urandom); y_in = 3'($urandom); acc_in = ACC_W'($urandom);
      end
      if (last_strobe && got_n == 63) begin
        out_ready = 1'b1; ready_in = 1'b1;
        x_in = last_addr[2:0]; y_in = last_addr[5:3]; acc_in = ACC_W'($urandom);
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_data[got_n] = out_data; got_idx[got_n] = out_index; got_last[got_n] = out_last;
        got_n++;
      end
    end
    @(posedge clk); #1;
    ready_in = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (got_n !== 64) begin
      n_bad++;
      $display("FAIL %s beat count: got %0d want 64 (cycle budget %0d)", tag, got_n, cyc);
    end
    for (int k = 0; k < got_n; k++) begin
      got_by_idx[got_idx[k]] = got_data[k];
      n_cmp++;
      if (got_idx[k] !== scan[k] || got_data[k] !== exp_mem[scan[k]] || got_last[k] !== (k == 63)) begin
        n_bad++;
        $display("FAIL %s k=%0d: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                 tag, k, got_idx[k], got_data[k], got_last[k], scan[k], exp_mem[scan[k]], (k == 63));
      end
    end
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after drain: got valid=%b busy=%b want 0 0", tag, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    bit seen = 0;
    rst_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_last, busy, overflow_err, out_data, out_index} !== '0) begin
      n_bad++;
      $display("FAIL reset_init: got v=%b l=%b b=%b o=%b d=%h i=%0d want all 0",
               out_valid, out_last, busy, overflow_err, out_data, out_index);
    end
    @(posedge clk); #1 rst_in = 1'b1;
    send_shuffled(-1, 0);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL reset_fill valid: got %b want 1", out_valid); end
    @(negedge clk); #2 rst_in = 1'b0; #1;
    n_cmp++;
    if ({out_valid, out_last, busy, overflow_err, out_data, out_index} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got v=%b l=%b b=%b o=%b d=%h i=%0d want all 0",
               out_valid, out_last, busy, overflow_err, out_data, out_index);
    end
    @(posedge clk); #1 rst_in = 1'b1;
    repeat (20) begin @(negedge clk); if (out_valid) seen = 1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_idle: got valid seen=1 want 0"); end
    for (int a = 0; a < 32; a++) strobe(6'(a), rand_acc(), 1);
    @(negedge clk); #2 rst_in = 1'b0;
    @(posedge clk); #1 rst_in = 1'b1;
    for (int a = 32; a < 64; a++) strobe(6'(a), rand_acc(), 1);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_partial: got valid=%b want 0", out_valid); end
    for (int a = 0; a < 32; a++) strobe(6'(a), rand_acc(), 1);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL reset_refill: got valid=%b want 1", out_valid); end
    drain_block("reset_refill", 100, -1, -1, 0, 6'd0);
  endtask

  task automatic test_raster();
    for (int a = 0; a < 64; a++) begin
      if (a == 63) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL raster early valid: got %b want 0", out_valid); end
      end
      strobe(6'(a), ACC_W'(8 * a), 1);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL raster latency: got valid=%b busy=%b want 1 1", out_valid, busy);
    end
    drain_block("raster", 100, -1, -1, 0, 6'd0);
  endtask

  task automatic test_saturation();
    for (int a = 0; a < 64; a++) begin
      case (a)
        0: strobe(6'(a), 24'h7FFFFF, 1);
        1: strobe(6'(a), 24'h800000, 1);
        2: strobe(6'(a), 24'hFFFFF7, 1);
        3: strobe(6'(a), 24'd262143, 1);
        4: strobe(6'(a), 24'd262144, 1);
        default: strobe(6'(a), rand_acc(), 1);
      endcase
    end
    drain_block("sat", 80, -1, -1, 0, 6'd0);
    n_cmp++;
    if (got_by_idx[0] !== 16'h7FFF || got_by_idx[1] !== 16'h8000 || got_by_idx[2] !== 16'hFFFE ||
        got_by_idx[3] !== 16'h7FFF || got_by_idx[4] !== 16'h7FFF) begin
      n_bad++;
      $display("FAIL sat values: got %h %h %h %h %h want 7fff 8000 fffe 7fff 7fff",
               got_by_idx[0], got_by_idx[1], got_by_idx[2], got_by_idx[3], got_by_idx[4]);
    end
  endtask

  task automatic test_backpressure();
    send_shuffled(-1, 0);
    drain_block("bp", 100, 10, -1, 0, 6'd0);
  endtask

  task automatic test_dup_wide();
    strobe(6'd27, 24'd40, 1);
    strobe(6'd27, 24'd56, 3);
    for (int a = 0; a < 64; a++) begin
      if (a != 27) begin
        if (a == 63) begin
          n_cmp++;
          if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dup early valid: got %b want 0", out_valid); end
        end
        strobe(6'(a), rand_acc(), 1);
      end
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dup valid: got %b want 1", out_valid); end
    drain_block("dup", 60, -1, -1, 0, 6'd0);
    n_cmp++;
    if (got_by_idx[27] !== 16'd7) begin n_bad++; $display("FAIL dup addr27: got %h want 0007", got_by_idx[27]); end
  endtask

  task automatic test_overflow();
    n_cmp++;
    if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL ovf pre: got %b want 0", overflow_err); end
    send_shuffled(-1, 10);
    drain_block("ovf", 70, -1, 20, 1, 6'd21);
    n_cmp++;
    if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf flag: got %b want 1", overflow_err); end
    send_shuffled(21, 10);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf dropped kept: got valid=%b want 0", out_valid); end
    strobe(6'd21, rand_acc(), 1);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ovf next valid: got %b want 1", out_valid); end
    drain_block("ovf_next", 100, -1, -1, 0, 6'd0);
    n_cmp++;
    if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf sticky: got %b want 1", overflow_err); end
    @(negedge clk); rst_in = 1'b0; #1;
    n_cmp++;
    if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL ovf reset: got %b want 0", overflow_err); end
    @(posedge clk); #1 rst_in = 1'b1;
  endtask

  task automatic test_random();
    for (int b = 0; b < 3; b++) begin
      send_shuffled(-1, 20);
      drain_block("rand", int'($urandom_range(30, 100)), (b == 1) ? 40 : -1, -1, 0, 6'd0);
    end
  endtask

  initial begin
    build_scan();
    test_reset();
    test_raster();
    test_saturation();
    test_backpressure();
    test_dup_wide();
    test_overflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
